// File: rtl/decode_stage_p.sv
// RV32I/RV32E decode stage: register file with write-through bypass,
// immediate generation, ALU-op decode, load-use stall and one elastic
// valid/ready output slot feeding execute.
module decode_stage_p #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_instr,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic [3:0]      out_alu_op,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_reg_write,
    output logic            out_use_imm,
    output logic            out_use_pc,
    output logic            out_is_branch,
    output logic            out_is_jump,
    output logic            out_illegal
);

    localparam int         RAW        = $clog2(NUM_REGS);
    localparam logic [5:0] NUM_REGS_W = 6'(NUM_REGS);
    localparam bit         IS64       = (XLEN == 64);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [3:0] ALU_ADD     = 4'd0;
    localparam logic [3:0] ALU_SUB     = 4'd1;
    localparam logic [3:0] ALU_SLL     = 4'd2;
    localparam logic [3:0] ALU_SLT     = 4'd3;
    localparam logic [3:0] ALU_SLTU    = 4'd4;
    localparam logic [3:0] ALU_XOR     = 4'd5;
    localparam logic [3:0] ALU_SRL     = 4'd6;
    localparam logic [3:0] ALU_SRA     = 4'd7;
    localparam logic [3:0] ALU_OR      = 4'd8;
    localparam logic [3:0] ALU_AND     = 4'd9;
    localparam logic [3:0] ALU_PASS_B  = 4'd10;
    localparam logic [3:0] ALU_INVALID = 4'd15;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [3:0]      alu_op;
        logic            mem_read;
        logic            mem_write;
        logic            reg_write;
        logic            use_imm;
        logic            use_pc;
        logic            is_branch;
        logic            is_jump;
        logic            illegal;
    } slot_t;

    // Register index exists in this configuration (RV32E has only 16).
    function automatic logic idx_ok(input logic [4:0] idx);
        return ({1'b0, idx} < NUM_REGS_W);
    endfunction

    // funct3 to ALU op; alt selects SUB/SRA on the 000/101 encodings.
    function automatic logic [3:0] f3_op(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_INVALID;
        endcase
        return op;
    endfunction

    // Empty slot contents: everything zero, ALU op marked invalid.
    function automatic slot_t slot_reset();
        slot_t s;
        s        = '0;
        s.alu_op = ALU_INVALID;
        return s;
    endfunction

    logic [XLEN-1:0] rf_q [NUM_REGS];
    logic [XLEN-1:0] rf_d [NUM_REGS];
    slot_t           slot_q, slot_d, dec_s;
    logic            valid_q, valid_d;

    logic [6:0]  opcode_s, f7_s, sh_f7_s;
    logic [4:0]  rd_s, rs1_s, rs2_s;
    logic [2:0]  f3_s;
    logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s, imm32_s;
    logic        wr_ok_s, known_s, f7_bad_s, idx_bad_s, illegal_s;
    logic        uses_rs1_s, uses_rs2_s, uses_rd_s;
    logic        advance_s, hazard_s, in_ready_s;

    assign opcode_s = in_instr[6:0];
    assign rd_s     = in_instr[11:7];
    assign f3_s     = in_instr[14:12];
    assign rs1_s    = in_instr[19:15];
    assign rs2_s    = in_instr[24:20];
    assign f7_s     = in_instr[31:25];
    // In RV64 funct7[0] is the top shamt bit, not part of the opcode check.
    assign sh_f7_s  = IS64 ? {in_instr[31:26], 1'b0} : in_instr[31:25];

    assign imm_i_s = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b_s = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u_s = {in_instr[31:12], 12'h000};
    assign imm_j_s = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0};

    assign wr_ok_s = wb_en && (wb_addr != 5'd0) && idx_ok(wb_addr);

    // Next register-file contents: at most one entry replaced by write-back.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            rf_d[i] = (wr_ok_s && (wb_addr == 5'(i))) ? wb_data : rf_q[i];
        end
    end

    // Register file storage; x0 is never written so it stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= {XLEN{1'b0}};
            end
        end else begin
            rf_q <= rf_d;
        end
    end

    // Instruction decode into a candidate slot, including bypassed reads.
    always_comb begin
        dec_s      = '0;
        known_s    = 1'b1;
        f7_bad_s   = 1'b0;
        uses_rs1_s = 1'b0;
        uses_rs2_s = 1'b0;
        uses_rd_s  = 1'b0;
        imm32_s    = 32'h0000_0000;
        dec_s.alu_op = ALU_INVALID;
        case (opcode_s)
            OP_R: begin
                uses_rs1_s = 1'b1;
                uses_rs2_s = 1'b1;
                uses_rd_s  = 1'b1;
                if (f7_s == 7'b0000000) begin
                    dec_s.alu_op = f3_op(f3_s, 1'b0);
                end else if ((f7_s == 7'b0100000) &&
                             ((f3_s == 3'b000) || (f3_s == 3'b101))) begin
                    dec_s.alu_op = f3_op(f3_s, 1'b1);
                end else begin
                    f7_bad_s = 1'b1;
                end
            end
            OP_IALU: begin
                uses_rs1_s    = 1'b1;
                uses_rd_s     = 1'b1;
                dec_s.use_imm = 1'b1;
                imm32_s       = imm_i_s;
                case (f3_s)
                    3'b001: begin
                        if (sh_f7_s == 7'b0000000) dec_s.alu_op = ALU_SLL;
                        else                       f7_bad_s     = 1'b1;
                    end
                    3'b101: begin
                        if (sh_f7_s == 7'b0000000)      dec_s.alu_op = ALU_SRL;
                        else if (sh_f7_s == 7'b0100000) dec_s.alu_op = ALU_SRA;
                        else                            f7_bad_s     = 1'b1;
                    end
                    default: dec_s.alu_op = f3_op(f3_s, 1'b0);
                endcase
            end
            OP_LOAD: begin
                uses_rs1_s     = 1'b1;
                uses_rd_s      = 1'b1;
                dec_s.use_imm  = 1'b1;
                dec_s.mem_read = 1'b1;
                dec_s.alu_op   = ALU_ADD;
                imm32_s        = imm_i_s;
            end
            OP_JALR: begin
                uses_rs1_s    = 1'b1;
                uses_rd_s     = 1'b1;
                dec_s.use_imm = 1'b1;
                dec_s.is_jump = 1'b1;
                dec_s.alu_op  = ALU_ADD;
                imm32_s       = imm_i_s;
            end
            OP_STORE: begin
                uses_rs1_s      = 1'b1;
                uses_rs2_s      = 1'b1;
                dec_s.use_imm   = 1'b1;
                dec_s.mem_write = 1'b1;
                dec_s.alu_op    = ALU_ADD;
                imm32_s         = imm_s_s;
            end
            OP_BRANCH: begin
                uses_rs1_s      = 1'b1;
                uses_rs2_s      = 1'b1;
                dec_s.use_pc    = 1'b1;
                dec_s.is_branch = 1'b1;
                dec_s.alu_op    = ALU_ADD;
                imm32_s         = imm_b_s;
            end
            OP_LUI: begin
                uses_rd_s     = 1'b1;
                dec_s.use_imm = 1'b1;
                dec_s.alu_op  = ALU_PASS_B;
                imm32_s       = imm_u_s;
            end
            OP_AUIPC: begin
                uses_rd_s     = 1'b1;
                dec_s.use_imm = 1'b1;
                dec_s.use_pc  = 1'b1;
                dec_s.alu_op  = ALU_ADD;
                imm32_s       = imm_u_s;
            end
            OP_JAL: begin
                uses_rd_s     = 1'b1;
                dec_s.use_imm = 1'b1;
                dec_s.use_pc  = 1'b1;
                dec_s.is_jump = 1'b1;
                dec_s.alu_op  = ALU_ADD;
                imm32_s       = imm_j_s;
            end
            OP_SYSTEM: begin
                imm32_s = imm_i_s;
            end
            default: begin
                known_s = 1'b0;
            end
        endcase

        idx_bad_s = (uses_rd_s  && !idx_ok(rd_s))  ||
                    (uses_rs1_s && !idx_ok(rs1_s)) ||
                    (uses_rs2_s && !idx_ok(rs2_s));
        illegal_s = !known_s || f7_bad_s || idx_bad_s;

        dec_s.pc     = in_pc;
        dec_s.imm    = XLEN'($signed(imm32_s));
        dec_s.rs1    = rs1_s;
        dec_s.rs2    = rs2_s;
        dec_s.rd     = rd_s;
        dec_s.funct3 = f3_s;
        dec_s.reg_write = uses_rd_s && (rd_s != 5'd0);
        dec_s.illegal   = illegal_s;
        if (illegal_s) begin
            dec_s.alu_op    = ALU_INVALID;
            dec_s.reg_write = 1'b0;
            dec_s.mem_read  = 1'b0;
            dec_s.mem_write = 1'b0;
        end else begin
            dec_s.alu_op = dec_s.alu_op;
        end

        // Source reads: out-of-range or x0 give zero; a same-cycle write wins.
        if ((rs1_s != 5'd0) && idx_ok(rs1_s)) begin
            dec_s.rs1_data = (wr_ok_s && (wb_addr == rs1_s)) ? wb_data
                                                             : rf_q[rs1_s[RAW-1:0]];
        end else begin
            dec_s.rs1_data = {XLEN{1'b0}};
        end
        if ((rs2_s != 5'd0) && idx_ok(rs2_s)) begin
            dec_s.rs2_data = (wr_ok_s && (wb_addr == rs2_s)) ? wb_data
                                                             : rf_q[rs2_s[RAW-1:0]];
        end else begin
            dec_s.rs2_data = {XLEN{1'b0}};
        end
    end

    // Slot handshake: flush beats load-use stall beats normal advance.
    always_comb begin
        advance_s  = out_ready || !valid_q;
        hazard_s   = valid_q && slot_q.mem_read && (slot_q.rd != 5'd0) &&
                     ((uses_rs1_s && (rs1_s == slot_q.rd)) ||
                      (uses_rs2_s && (rs2_s == slot_q.rd)));
        valid_d    = valid_q;
        slot_d     = slot_q;
        in_ready_s = 1'b0;
        if (advance_s) begin
            if (flush) begin
                valid_d    = 1'b0;
                in_ready_s = 1'b1;
            end else if (hazard_s) begin
                valid_d    = 1'b0;
                in_ready_s = 1'b0;
            end else begin
                valid_d    = in_valid;
                in_ready_s = 1'b1;
                slot_d     = dec_s;
            end
        end else begin
            in_ready_s = 1'b0;
            valid_d    = flush ? 1'b0 : valid_q;
        end
    end

    // Output slot register; reset discards any held instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            slot_q  <= slot_reset();
        end else begin
            valid_q <= valid_d;
            slot_q  <= slot_d;
        end
    end

    assign in_ready      = rst_n && in_ready_s;
    assign out_valid     = valid_q;
    assign out_pc        = slot_q.pc;
    assign out_rs1_data  = slot_q.rs1_data;
    assign out_rs2_data  = slot_q.rs2_data;
    assign out_imm       = slot_q.imm;
    assign out_rs1       = slot_q.rs1;
    assign out_rs2       = slot_q.rs2;
    assign out_rd        = slot_q.rd;
    assign out_funct3    = slot_q.funct3;
    assign out_alu_op    = slot_q.alu_op;
    assign out_mem_read  = slot_q.mem_read;
    assign out_mem_write = slot_q.mem_write;
    assign out_reg_write = slot_q.reg_write;
    assign out_use_imm   = slot_q.use_imm;
    assign out_use_pc    = slot_q.use_pc;
    assign out_is_branch = slot_q.is_branch;
    assign out_is_jump   = slot_q.is_jump;
    assign out_illegal   = slot_q.illegal;

endmodule

// File: tb/tb_decode_stage_p.sv
// Directed bench for decode_stage_p: a vector table for single-instruction
// decode plus hand-written sequences for bypass, load-use, stall/flush,
// RV32E index checks and asynchronous reset.
module tb_decode_stage_p;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, flush, wb_en, out_valid, out_ready;
    logic [31:0] in_pc, in_instr, wb_data;
    logic [4:0]  wb_addr;
    logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [2:0]  out_funct3;
    logic [3:0]  out_alu_op;
    logic        out_mem_read, out_mem_write, out_reg_write, out_use_imm;
    logic        out_use_pc, out_is_branch, out_is_jump, out_illegal;

    // Outputs of the RV32E (NUM_REGS=16) instance
    logic        e_in_ready, e_out_valid;
    logic [31:0] e_out_pc, e_out_rs1_data, e_out_rs2_data, e_out_imm;
    logic [4:0]  e_out_rs1, e_out_rs2, e_out_rd;
    logic [2:0]  e_out_funct3;
    logic [3:0]  e_out_alu_op;
    logic        e_out_mem_read, e_out_mem_write, e_out_reg_write, e_out_use_imm;
    logic        e_out_use_pc, e_out_is_branch, e_out_is_jump, e_out_illegal;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    decode_stage_p #(.XLEN(32), .NUM_REGS(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .flush(flush), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_rs1_data(out_rs1_data),
        .out_rs2_data(out_rs2_data), .out_imm(out_imm), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_rd(out_rd), .out_funct3(out_funct3),
        .out_alu_op(out_alu_op), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_reg_write(out_reg_write),
        .out_use_imm(out_use_imm), .out_use_pc(out_use_pc),
        .out_is_branch(out_is_branch), .out_is_jump(out_is_jump),
        .out_illegal(out_illegal)
    );

    decode_stage_p #(.XLEN(32), .NUM_REGS(16)) u_dut_e (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(e_in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .flush(flush), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(e_out_valid),
        .out_ready(out_ready), .out_pc(e_out_pc), .out_rs1_data(e_out_rs1_data),
        .out_rs2_data(e_out_rs2_data), .out_imm(e_out_imm), .out_rs1(e_out_rs1),
        .out_rs2(e_out_rs2), .out_rd(e_out_rd), .out_funct3(e_out_funct3),
        .out_alu_op(e_out_alu_op), .out_mem_read(e_out_mem_read),
        .out_mem_write(e_out_mem_write), .out_reg_write(e_out_reg_write),
        .out_use_imm(e_out_use_imm), .out_use_pc(e_out_use_pc),
        .out_is_branch(e_out_is_branch), .out_is_jump(e_out_is_jump),
        .out_illegal(e_out_illegal)
    );

    localparam logic [7:0] F_MR = 8'h80, F_MW = 8'h40, F_RW = 8'h20, F_UI = 8'h10;
    localparam logic [7:0] F_UP = 8'h08, F_BR = 8'h04, F_JP = 8'h02, F_IL = 8'h01;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [7:0]  flags;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] flags_now();
        return {out_mem_read, out_mem_write, out_reg_write, out_use_imm,
                out_use_pc, out_is_branch, out_is_jump, out_illegal};
    endfunction

    initial begin
        tbl[0]  = '{32'h00500093, 5'd1,  32'h00000005, 4'd0,  F_RW | F_UI};
        tbl[1]  = '{32'h12345137, 5'd2,  32'h12345000, 4'd10, F_RW | F_UI};
        tbl[2]  = '{32'h402083B3, 5'd7,  32'h00000000, 4'd1,  F_RW};
        tbl[3]  = '{32'h0000A183, 5'd3,  32'h00000000, 4'd0,  F_MR | F_RW | F_UI};
        tbl[4]  = '{32'hFE208EE3, 5'd29, 32'hFFFFFFFC, 4'd0,  F_UP | F_BR};
        tbl[5]  = '{32'h008000EF, 5'd1,  32'h00000008, 4'd0,  F_RW | F_UI | F_UP | F_JP};
        tbl[6]  = '{32'hFF1FF2EF, 5'd5,  32'hFFFFFFF0, 4'd0,  F_RW | F_UI | F_UP | F_JP};
        tbl[7]  = '{32'h00008067, 5'd0,  32'h00000000, 4'd0,  F_UI | F_JP};
        tbl[8]  = '{32'hFE20AC23, 5'd24, 32'hFFFFFFF8, 4'd0,  F_MW | F_UI};
        tbl[9]  = '{32'h00001217, 5'd4,  32'h00001000, 4'd0,  F_RW | F_UI | F_UP};
        tbl[10] = '{32'h4030D293, 5'd5,  32'h00000403, 4'd7,  F_RW | F_UI};
        tbl[11] = '{32'h02009093, 5'd1,  32'h00000020, 4'd15, F_UI | F_IL};
        tbl[12] = '{32'hFFFFFFFF, 5'd31, 32'h00000000, 4'd15, F_IL};
        tbl[13] = '{32'h00000073, 5'd0,  32'h00000000, 4'd15, 8'h00};
        tbl[14] = '{32'h40001033, 5'd0,  32'h00000000, 4'd15, F_IL};
        tbl[15] = '{32'h0020C433, 5'd8,  32'h00000000, 4'd5,  F_RW};
        tbl[16] = '{32'hFFF0B493, 5'd9,  32'hFFFFFFFF, 4'd4,  F_RW | F_UI};

        rst_n = 1'b0; in_valid = 1'b0; in_pc = 32'h0; in_instr = 32'h0;
        flush = 1'b0; wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0; out_ready = 1'b1;
        step();
        step();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_alu_op", {28'd0, out_alu_op}, 32'd15);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_imm", out_imm, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Register file starts cleared: x5 reads zero
        in_valid = 1'b1; in_instr = 32'h00528333; in_pc = 32'h00000100;
        step();
        chk("rf_reset_rs1", out_rs1_data, 32'd0);
        chk("rf_reset_rs2", out_rs2_data, 32'd0);

        for (int i = 0; i < 17; i++) begin
            in_instr = tbl[i].instr;
            in_pc    = 32'h00001000 + 32'(i * 4);
            #1;
            chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            step();
            chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("v%0d_pc", i), out_pc, 32'h00001000 + 32'(i * 4));
            chk($sformatf("v%0d_rd", i), {27'd0, out_rd}, {27'd0, tbl[i].rd});
            chk($sformatf("v%0d_imm", i), out_imm, tbl[i].imm);
            chk($sformatf("v%0d_alu", i), {28'd0, out_alu_op}, {28'd0, tbl[i].alu});
            chk($sformatf("v%0d_flags", i), {24'd0, flags_now()}, {24'd0, tbl[i].flags});
        end

        // Write-through bypass, persistence, and x0 write suppression
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF; in_instr = 32'h00028333;
        step();
        wb_en = 1'b0;
        chk("byp_rs1", out_rs1_data, 32'hDEADBEEF);
        chk("byp_rs2", out_rs2_data, 32'd0);
        chk("byp_rd", {27'd0, out_rd}, 32'd6);
        in_instr = 32'h00528333;
        step();
        chk("rf_keep_rs1", out_rs1_data, 32'hDEADBEEF);
        chk("rf_keep_rs2", out_rs2_data, 32'hDEADBEEF);
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h12345678; in_instr = 32'h00000333;
        step();
        wb_en = 1'b0;
        chk("x0_byp", out_rs1_data, 32'd0);
        step();
        chk("x0_keep", out_rs2_data, 32'd0);

        // Load-use: one bubble, then the dependent add
        in_instr = 32'h0000A183; in_pc = 32'h00001F00;
        step();
        chk("lu_lw_mr", {31'd0, out_mem_read}, 32'd1);
        chk("lu_lw_f3", {29'd0, out_funct3}, 32'd2);
        in_instr = 32'h00318233; in_pc = 32'h00001F04;
        #1;
        chk("lu_stall_ready", {31'd0, in_ready}, 32'd0);
        step();
        chk("lu_bubble", {31'd0, out_valid}, 32'd0);
        chk("lu_after_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("lu_add_valid", {31'd0, out_valid}, 32'd1);
        chk("lu_add_rd", {27'd0, out_rd}, 32'd4);
        chk("lu_add_rs1", {27'd0, out_rs1}, 32'd3);
        chk("lu_add_pc", out_pc, 32'h00001F04);
        // Load followed by add x4,x0,x0: no bubble
        in_instr = 32'h0000A183; in_pc = 32'h00001F08;
        step();
        in_instr = 32'h00000233; in_pc = 32'h00002000;
        #1;
        chk("nolu_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("nolu_valid", {31'd0, out_valid}, 32'd1);
        chk("nolu_pc", out_pc, 32'h00002000);

        // Back-pressure: slot holds for three cycles, then flush with advance=0
        out_ready = 1'b0; in_instr = 32'h00500093; in_pc = 32'h00003000;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stall%0d_ready", c), {31'd0, in_ready}, 32'd0);
            step();
            chk($sformatf("stall%0d_valid", c), {31'd0, out_valid}, 32'd1);
            chk($sformatf("stall%0d_pc", c), out_pc, 32'h00002000);
            chk($sformatf("stall%0d_rd", c), {27'd0, out_rd}, 32'd4);
            chk($sformatf("stall%0d_imm", c), out_imm, 32'd0);
        end
        flush = 1'b1;
        #1;
        chk("flush_hold_ready", {31'd0, in_ready}, 32'd0);
        step();
        chk("flush_hold_valid", {31'd0, out_valid}, 32'd0);
        flush = 1'b0; out_ready = 1'b1;
        #1;
        chk("resume_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("resume_valid", {31'd0, out_valid}, 32'd1);
        chk("resume_pc", out_pc, 32'h00003000);
        chk("resume_imm", out_imm, 32'd5);
        // Flush with advance=1 consumes and drops the incoming instruction
        flush = 1'b1; in_instr = 32'h00000233; in_pc = 32'h00003004;
        #1;
        chk("flush_adv_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("flush_adv_valid", {31'd0, out_valid}, 32'd0);
        flush = 1'b0; in_valid = 1'b0;
        step();
        chk("flush_idle_valid", {31'd0, out_valid}, 32'd0);

        // addi x17: legal in RV32I, illegal in RV32E
        in_valid = 1'b1; in_instr = 32'h01000893; in_pc = 32'h00004000;
        step();
        chk("rv32i_x17_illegal", {31'd0, out_illegal}, 32'd0);
        chk("rv32i_x17_rw", {31'd0, out_reg_write}, 32'd1);
        chk("rv32e_x17_valid", {31'd0, e_out_valid}, 32'd1);
        chk("rv32e_x17_illegal", {31'd0, e_out_illegal}, 32'd1);
        chk("rv32e_x17_rw", {31'd0, e_out_reg_write}, 32'd0);
        chk("rv32e_x17_alu", {28'd0, e_out_alu_op}, 32'd15);

        // Asynchronous reset in the middle of a stream
        in_instr = 32'h00500093; in_pc = 32'h00004004;
        step();
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        chk("mid_rst_alu", {28'd0, out_alu_op}, 32'd15);
        chk("mid_rst_rd", {27'd0, out_rd}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
